// File: rtl/complement_2s.sv
// Registered W-bit negator: two's complement (mode=0) or one's complement (mode=1) with valid/zero/ovf flags.
// Optional macro COMPLEMENT_2S_SAT_EN: saturate the most-negative operand to the most-positive value in mode 0.
module complement_2s #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] data,
    input  logic         mode,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         zero,
    output logic         ovf
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ZERO = {W{1'b0}};

    function automatic logic [W-1:0] negate(input logic [W-1:0] a);
        return ~a + ONE;
    endfunction

    logic [W-1:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;

    // Next-state: accepted words produce a fresh result, idle cycles hold result and flags.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            valid_d = 1'b1;
            if (mode) begin
                out_d = ~data;
                ovf_d = 1'b0;
            end else begin
                ovf_d = (data == MOST_NEG);
`ifdef COMPLEMENT_2S_SAT_EN
                if (data == MOST_NEG) begin
                    out_d = MOST_POS;
                end else begin
                    out_d = negate(data);
                end
`else
                out_d = negate(data);
`endif
            end
            zero_d = (out_d == ALL_ZERO);
        end else begin
            valid_d = 1'b0;
        end
    end

    // Result and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= ALL_ZERO;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_complement_2s.sv
// Self-checking bench for complement_2s: arithmetic reference model checked every cycle plus directed literal pins.
module tb_complement_2s;

    localparam int W = 4;
    localparam int MODV = 2 ** W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] data;
    logic         mode;
    logic [W-1:0] out;
    logic         out_valid;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    complement_2s #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .data     (data),
        .mode     (mode),
        .out      (out),
        .out_valid(out_valid),
        .zero     (zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on integers.
    logic [W-1:0] exp_out;
    logic         exp_valid, exp_zero, exp_ovf, model_ok;
    int           acc_data;
    logic         acc_mode;
    int           m_val, m_res;
    logic         m_ovf;

    initial model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_out   <= '0;
            exp_valid <= 1'b0;
            exp_zero  <= 1'b0;
            exp_ovf   <= 1'b0;
            model_ok  <= 1'b1;
        end else if (in_valid) begin
            m_val = int'(data);
            m_ovf = 1'b0;
            if (mode) begin
                m_res = (MODV - 1) - m_val;
            end else begin
                m_res = (MODV - m_val) % MODV;
                if (m_val == MODV / 2) begin
                    m_ovf = 1'b1;
`ifdef COMPLEMENT_2S_SAT_EN
                    m_res = MODV / 2 - 1;
`endif
                end
            end
            exp_out   <= m_res[W-1:0];
            exp_valid <= 1'b1;
            exp_zero  <= (m_res == 0);
            exp_ovf   <= m_ovf;
            acc_data  <= m_val;
            acc_mode  <= mode;
        end else begin
            exp_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Compare DUT against model on the falling edge, once the model has seen reset.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_out", int'(out), int'(exp_out));
            check("model_valid", int'(out_valid), int'(exp_valid));
            check("model_zero", int'(zero), int'(exp_zero));
            check("model_ovf", int'(ovf), int'(exp_ovf));
            if (out_valid && !acc_mode && !ovf)
                check("identity", (acc_data + int'(out)) % MODV, 0);
        end
    end

    task automatic tick(input logic r, input logic v, input logic [W-1:0] d, input logic m);
        rst_n    = r;
        in_valid = v;
        data     = d;
        mode     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [W-1:0] eo, input logic ev,
                       input logic ez, input logic eovf);
        check({name, "_out"}, int'(out), int'(eo));
        check({name, "_valid"}, int'(out_valid), int'(ev));
        check({name, "_zero"}, int'(zero), int'(ez));
        check({name, "_ovf"}, int'(ovf), int'(eovf));
    endtask

    logic [W-1:0] sweep_exp [16];
    logic [W-1:0] min_neg_res;

    initial begin
        sweep_exp = '{4'b0000, 4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1001,
                      4'b1000, 4'b0111, 4'b0110, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0001};
`ifdef COMPLEMENT_2S_SAT_EN
        min_neg_res = 4'b0111;
        sweep_exp[8] = 4'b0111;
`else
        min_neg_res = 4'b1000;
`endif
        rst_n = 1'b0; in_valid = 1'b0; data = '0; mode = 1'b0;

        tick(1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 1'b0);
        pin("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b1, 4'(i), 1'b0);
            check("sweep_out", int'(out), int'(sweep_exp[i]));
            check("sweep_valid", int'(out_valid), 1);
        end

        tick(1'b1, 1'b1, 4'd0, 1'b0);
        pin("zero_in", 4'b0000, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 4'd8, 1'b0);
        pin("most_neg", min_neg_res, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 4'd3, 1'b0);
        pin("three", 4'b1101, 1'b1, 1'b0, 1'b0);

        tick(1'b1, 1'b1, 4'd5, 1'b1);
        pin("ones_5", 4'b1010, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'd15, 1'b1);
        pin("ones_15", 4'b0000, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 4'd8, 1'b1);
        pin("ones_8", 4'b0111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 4'd6, 1'(i % 2));
            check("alt_out", int'(out), (i % 2 == 0) ? 10 : 9);
        end

        tick(1'b1, 1'b1, 4'd2, 1'b0);
        pin("hold_load", 4'b1110, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
            pin("hold", 4'b1110, 1'b0, 1'b0, 1'b0);
        end

        tick(1'b1, 1'b1, 4'd8, 1'b0);
        tick(1'b0, 1'b1, 4'd4, 1'b0);
        pin("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'd4, 1'b0);
        pin("after_reset", 4'b1100, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            tick(1'($urandom_range(49, 0) != 0),
                 1'($urandom_range(3, 0) != 0),
                 4'($urandom_range(15, 0)),
                 1'($urandom_range(1, 0)));
        end
        tick(1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
